// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: atan2(y,x) in Q3.29 and vector magnitude, one micro-rotation per clock.
// Define CORDIC_ATAN2_MAG_EN to build the gain-compensated magnitude multiplier; otherwise mag_out is 0.
module cordic_atan2 #(
    parameter int ITERATIONS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic               input_valid,
    output logic signed [31:0] angle_out,
    output logic        [15:0] mag_out,
    output logic               out_valid,
    output logic               busy
);

    localparam int FRAC = 8;
    // Two integer bits above the 16-bit input range absorb the CORDIC gain (~1.65 * sqrt 2) on a negated full-scale vector.
    localparam int DW = 16 + 2 + FRAC;
    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);
    localparam logic signed [31:0] PI = 32'sh6487ED51;

    logic                 busy_q, busy_d;
    logic                 outValid_q, outValid_d;
    logic                 zeroIn_q, zeroIn_d;
    logic [4:0]           iterCnt_q, iterCnt_d;
    logic signed [DW-1:0] xAcc_q, xAcc_d;
    logic signed [DW-1:0] yAcc_q, yAcc_d;
    logic signed [31:0]   zAcc_q, zAcc_d;
    logic signed [31:0]   angle_q, angle_d;
    logic [15:0]          mag_q, mag_d;

    logic signed [DW-1:0] xExt, yExt, xPre, yPre, xIter, yIter;
    logic signed [31:0]   zPre, zIter, atanStep;
    logic [15:0]          magNext;

    function automatic logic signed [31:0] atanRom(input logic [4:0] idx);
        case (idx)
            5'd0:    atanRom = 32'sd421657428;
            5'd1:    atanRom = 32'sd248918915;
            5'd2:    atanRom = 32'sd131521918;
            5'd3:    atanRom = 32'sd66762579;
            5'd4:    atanRom = 32'sd33510843;
            5'd5:    atanRom = 32'sd16771758;
            5'd6:    atanRom = 32'sd8387925;
            5'd7:    atanRom = 32'sd4194219;
            5'd8:    atanRom = 32'sd2097141;
            5'd9:    atanRom = 32'sd1048575;
            5'd10:   atanRom = 32'sd524288;
            5'd11:   atanRom = 32'sd262144;
            5'd12:   atanRom = 32'sd131072;
            5'd13:   atanRom = 32'sd65536;
            5'd14:   atanRom = 32'sd32768;
            5'd15:   atanRom = 32'sd16384;
            5'd16:   atanRom = 32'sd8192;
            5'd17:   atanRom = 32'sd4096;
            5'd18:   atanRom = 32'sd2048;
            5'd19:   atanRom = 32'sd1024;
            default: atanRom = '0;
        endcase
    endfunction

    // Left half-plane inputs are folded into the right half-plane so the rotations only need to cover +/- pi/2.
    always_comb begin
        xExt = {{(DW-16-FRAC){x_in[15]}}, x_in, {FRAC{1'b0}}};
        yExt = {{(DW-16-FRAC){y_in[15]}}, y_in, {FRAC{1'b0}}};
        if (x_in[15]) begin
            xPre = -xExt;
            yPre = -yExt;
            zPre = y_in[15] ? -PI : PI;
        end else begin
            xPre = xExt;
            yPre = yExt;
            zPre = '0;
        end

        atanStep = atanRom(iterCnt_q);
        if (!yAcc_q[DW-1]) begin
            xIter = xAcc_q + (yAcc_q >>> iterCnt_q);
            yIter = yAcc_q - (xAcc_q >>> iterCnt_q);
            zIter = zAcc_q + atanStep;
        end else begin
            xIter = xAcc_q - (yAcc_q >>> iterCnt_q);
            yIter = yAcc_q + (xAcc_q >>> iterCnt_q);
            zIter = zAcc_q - atanStep;
        end
    end

`ifdef CORDIC_ATAN2_MAG_EN
    localparam int MW = DW + 17;
    localparam logic signed [MW-1:0] MAG_GAIN  = MW'(17'sh09B75);
    localparam logic signed [MW-1:0] MAG_ROUND = MW'(1 << (FRAC + 15));

    logic signed [MW-1:0] magProd;
    logic [18:0]          magInt;

    always_comb begin
        magProd = (MW'(xIter) * MAG_GAIN) + MAG_ROUND;
        magInt  = 19'(magProd >>> (FRAC + 16));
        if (xIter[DW-1]) begin
            magNext = '0;
        end else if (magInt[18:16] != 3'b000) begin
            magNext = 16'hFFFF;
        end else begin
            magNext = magInt[15:0];
        end
    end
`else
    assign magNext = '0;
`endif

    always_comb begin
        busy_d     = busy_q;
        outValid_d = 1'b0;
        zeroIn_d   = zeroIn_q;
        iterCnt_d  = iterCnt_q;
        xAcc_d     = xAcc_q;
        yAcc_d     = yAcc_q;
        zAcc_d     = zAcc_q;
        angle_d    = angle_q;
        mag_d      = mag_q;

        if (busy_q) begin
            xAcc_d = xIter;
            yAcc_d = yIter;
            zAcc_d = zIter;
            if (iterCnt_q == LAST_ITER) begin
                busy_d     = 1'b0;
                outValid_d = 1'b1;
                iterCnt_d  = '0;
                angle_d    = zeroIn_q ? '0 : zIter;
                mag_d      = zeroIn_q ? '0 : magNext;
            end else begin
                iterCnt_d = iterCnt_q + 5'd1;
            end
        end else if (input_valid) begin
            busy_d    = 1'b1;
            iterCnt_d = '0;
            xAcc_d    = xPre;
            yAcc_d    = yPre;
            zAcc_d    = zPre;
            zeroIn_d  = (x_in == '0) && (y_in == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
            zeroIn_q   <= 1'b0;
            iterCnt_q  <= '0;
            xAcc_q     <= '0;
            yAcc_q     <= '0;
            zAcc_q     <= '0;
            angle_q    <= '0;
            mag_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            outValid_q <= outValid_d;
            zeroIn_q   <= zeroIn_d;
            iterCnt_q  <= iterCnt_d;
            xAcc_q     <= xAcc_d;
            yAcc_q     <= yAcc_d;
            zAcc_q     <= zAcc_d;
            angle_q    <= angle_d;
            mag_q      <= mag_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = outValid_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_atan2.sv
// Self-checking bench for cordic_atan2: directed literal cases plus randomized traffic against a real-arithmetic model.
// Magnitude expectations follow CORDIC_ATAN2_MAG_EN when it is defined for the build.
module tb_cordic_atan2;

    localparam int     ITER    = 20;
    localparam longint ANG_TOL = 131072;
`ifdef CORDIC_ATAN2_MAG_EN
    localparam bit     MAG_ON  = 1'b1;
    localparam longint MAG_TOL = 2;
`else
    localparam bit     MAG_ON  = 1'b0;
    localparam longint MAG_TOL = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               input_valid = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic signed [31:0] angle_out;
    logic        [15:0] mag_out;
    logic               out_valid;
    logic               busy;

    int tests = 0;
    int fails = 0;

    int     edgeNo   = 0;
    int     doneEdge = 0;
    int     opX      = 0;
    int     opY      = 0;
    bit     inFlight = 1'b0;
    bit     mValid   = 1'b0;
    longint mAngle   = 0;
    longint mMag     = 0;

    cordic_atan2 #(.ITERATIONS(ITER)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_in        (x_in),
        .y_in        (y_in),
        .input_valid (input_valid),
        .angle_out   (angle_out),
        .mag_out     (mag_out),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected, input longint tol);
        longint diff;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        tests++;
        if (diff > tol) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, actual, expected, tol, $time);
        end
    endtask

    function automatic longint refAngle(input int xv, input int yv);
        if (xv == 0 && yv == 0) return 0;
        return longint'($atan2(real'(yv), real'(xv)) * 536870912.0);
    endfunction

    function automatic longint refMag(input int xv, input int yv);
        if (!MAG_ON) return 0;
        return longint'($sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)));
    endfunction

    function automatic void randPair(output logic signed [15:0] xr, output logic signed [15:0] yr);
        int mode;
        int ax;
        int ay;
        mode = $urandom_range(0, 9);
        xr = 16'($urandom);
        yr = 16'($urandom);
        if (mode == 0) begin
            xr = '0;
            yr = '0;
        end else if (mode == 1) begin
            xr = -16'sd32768;
            yr = 16'(int'($urandom_range(0, 4)) - 2);
        end else if (mode == 2) begin
            xr = 16'(int'($urandom_range(0, 4)) - 2);
            yr = ($urandom_range(0, 1) == 1) ? 16'sd32767 : -16'sd32768;
        end
        ax = (xr < 0) ? -int'(xr) : int'(xr);
        ay = (yr < 0) ? -int'(yr) : int'(yr);
        if (mode != 0 && ax < 1024 && ay < 1024) xr = 16'sd1024;
    endfunction

    always @(posedge clk) edgeNo <= edgeNo + 1;

    // Reference: an accepted request completes exactly ITER edges after its accept edge; requests while in flight are dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inFlight <= 1'b0;
            mValid   <= 1'b0;
            mAngle   <= 0;
            mMag     <= 0;
        end else begin
            mValid <= 1'b0;
            if (inFlight) begin
                if (edgeNo == doneEdge) begin
                    inFlight <= 1'b0;
                    mValid   <= 1'b1;
                    mAngle   <= refAngle(opX, opY);
                    mMag     <= refMag(opX, opY);
                end
            end else if (input_valid) begin
                opX      <= x_in;
                opY      <= y_in;
                doneEdge <= edgeNo + ITER;
                inFlight <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", busy, inFlight, 0);
        checkOutput("out_valid", out_valid, mValid, 0);
        checkOutput("angle_out", angle_out, mAngle, ANG_TOL);
        checkOutput("mag_out", mag_out, mMag, MAG_TOL);
    end

    task automatic applyStimulus(input string name, input logic signed [15:0] xv, input logic signed [15:0] yv,
                                 input longint expAngle, input longint angTol, input longint expMag, input bit noise);
        int latency;
        x_in        = xv;
        y_in        = yv;
        input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        latency     = -1;
        for (int e = 1; e <= ITER + 5 && latency < 0; e++) begin
            input_valid = noise && (e == 5 || e == 19);
            if (input_valid) begin
                x_in = 16'sh7000;
                y_in = -16'sh3000;
            end
            @(posedge clk);
            @(negedge clk);
            if (out_valid) latency = e;
        end
        input_valid = 1'b0;
        checkOutput({name, "_latency"}, latency, ITER, 0);
        if (latency > 0) begin
            checkOutput({name, "_angle"}, angle_out, expAngle, angTol);
            checkOutput({name, "_mag"}, mag_out, MAG_ON ? expMag : 0, MAG_TOL);
        end
    endtask

    initial begin
        logic signed [15:0] xr;
        logic signed [15:0] yr;
        int seen;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0, 0);
        checkOutput("reset_valid", out_valid, 0, 0);
        checkOutput("reset_angle", angle_out, 0, 0);
        checkOutput("reset_mag", mag_out, 0, 0);
        rst_n = 1'b1;

        applyStimulus("diag45", 16384, 16384, 32'sh1921FB54, ANG_TOL, 23170, 1'b0);
        applyStimulus("up_ignored", 0, 16384, 32'sh3243F6A8, ANG_TOL, 16384, 1'b1);
        applyStimulus("down", 0, -16384, 32'shCDBC0958, ANG_TOL, 16384, 1'b0);
        applyStimulus("left", -16384, 0, 32'sh6487ED51, ANG_TOL, 16384, 1'b0);
        applyStimulus("zero", 0, 0, 0, 0, 0, 1'b0);
        applyStimulus("neg_full", -16'sd32768, -16'sd1, -longint'(32'sh6487ED51), ANG_TOL, 32768, 1'b0);

        x_in        = 16384;
        y_in        = -8000;
        input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0, 0);
        checkOutput("abort_valid", out_valid, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", seen, 0, 0);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            input_valid = ($urandom_range(0, 3) != 0);
            randPair(xr, yr);
            x_in = xr;
            y_in = yr;
        end
        @(negedge clk);
        input_valid = 1'b0;
        repeat (ITER + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
